// File: rtl/ann_sequencer_if.sv
// Handshake and datapath-control bundle between the inference sequencer and its surroundings.
// master = the sequencer, slave = the go/done requester plus the Neurons datapath.
interface ann_sequencer_if;
  logic       go;
  logic       neu_finish;
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] gp;
  logic       layer;
  logic [2:0] level;
  logic       neu_start;
  logic       neu_rst;
  logic [3:0] ld;
  logic [1:0] ld_ans;

  modport master (
    input  go, neu_finish,
    output busy, done, err, gp, layer, level, neu_start, neu_rst, ld, ld_ans
  );

  modport slave (
    output go, neu_finish,
    input  busy, done, err, gp, layer, level, neu_start, neu_rst, ld, ld_ans
  );
endinterface

// File: rtl/ann_sequencer.sv
// Two-layer ANN inference controller: walks hidden then output neuron groups,
// issuing clear/start, level addressing and one-hot load strobes to the datapath.
module ann_sequencer #(
  parameter int L0_GROUPS = 4,
  parameter int L0_LEVELS = 8,
  parameter int L1_GROUPS = 2,
  parameter int L1_LEVELS = 4,
  parameter int TIMEOUT   = 64
) (
  input  logic             clk,
  input  logic             rst,
  ann_sequencer_if.master  bus
);

  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0]        L0_LAST_GP = 2'(L0_GROUPS - 1);
  localparam logic [1:0]        L1_LAST_GP = 2'(L1_GROUPS - 1);
  localparam logic [2:0]        L0_LAST_LV = 3'(L0_LEVELS - 1);
  localparam logic [2:0]        L1_LAST_LV = 3'(L1_LEVELS - 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST  = WCNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_WAIT,
    S_STORE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        gp_q, gp_d;
  logic              layer_q, layer_d;
  logic [2:0]        level_q, level_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              fin_q, fin_d;

  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic       start_q, start_d;
  logic       nrst_q, nrst_d;
  logic [3:0] ld_q, ld_d;
  logic [1:0] ans_q, ans_d;

  logic [1:0] last_gp;
  logic [2:0] last_lv;

  assign last_gp = layer_q ? L1_LAST_GP : L0_LAST_GP;
  assign last_lv = layer_q ? L1_LAST_LV : L0_LAST_LV;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (which would infer a latch).
    state_d = state_q;
    gp_d    = gp_q;
    layer_d = layer_q;
    level_d = level_q;
    wcnt_d  = wcnt_q;
    fin_d   = fin_q;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    start_d = 1'b0;
    nrst_d  = 1'b0;
    ld_d    = '0;
    ans_d   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = S_CLR;
          level_d = '0;
          fin_d   = 1'b0;
          nrst_d  = 1'b1;
        end else begin
          busy_d = 1'b0;
        end
      end

      S_CLR: begin
        state_d = S_RUN;
        level_d = '0;
        start_d = 1'b1;
      end

      S_RUN: begin
        // Finish can arrive early; remember it so WAIT leaves on its first cycle.
        if (bus.neu_finish) fin_d = 1'b1;
        if (level_q == last_lv) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end else begin
          level_d = level_q + 3'd1;
        end
      end

      S_WAIT: begin
        if (bus.neu_finish || fin_q) begin
          state_d = S_STORE;
          if (layer_q) ans_d = 2'b01 << gp_q[0];
          else         ld_d  = 4'b0001 << gp_q;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          gp_d    = '0;
          layer_d = 1'b0;
          level_d = '0;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end

      S_STORE: begin
        if (gp_q != last_gp || !layer_q) begin
          state_d = S_CLR;
          level_d = '0;
          fin_d   = 1'b0;
          nrst_d  = 1'b1;
          if (gp_q != last_gp) begin
            gp_d = gp_q + 2'd1;
          end else begin
            gp_d    = '0;
            layer_d = 1'b1;
          end
        end else begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        gp_d    = '0;
        layer_d = 1'b0;
        level_d = '0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        gp_d    = '0;
        layer_d = 1'b0;
        level_d = '0;
      end
    endcase
  end

  // Async reset also kills any in-flight strobe in the same cycle it is asserted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gp_q    <= '0;
      layer_q <= 1'b0;
      level_q <= '0;
      wcnt_q  <= '0;
      fin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      nrst_q  <= 1'b0;
      ld_q    <= '0;
      ans_q   <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      state_q <= state_d;
      gp_q    <= gp_d;
      layer_q <= layer_d;
      level_q <= level_d;
      wcnt_q  <= wcnt_d;
      fin_q   <= fin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      nrst_q  <= nrst_d;
      ld_q    <= ld_d;
      ans_q   <= ans_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.gp        = gp_q;
  assign bus.layer     = layer_q;
  assign bus.level     = level_q;
  assign bus.neu_start = start_q;
  assign bus.neu_rst   = nrst_q;
  assign bus.ld        = ld_q;
  assign bus.ld_ans    = ans_q;

endmodule

// File: tb/tb_ann_sequencer.sv
// Cycle-locked scoreboard bench for ann_sequencer: each expected output cycle and the
// neu_finish stimulus for that cycle are queued up front, then popped one per clock.
module tb_ann_sequencer;

  logic clk;
  logic rst;

  ann_sequencer_if bus ();

  ann_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [1:0] gp;
    logic       layer;
    logic [2:0] level;
    logic       start;
    logic       nrst;
    logic [3:0] ld;
    logic [1:0] ans;
  } obs_t;

  typedef struct {
    logic fin;
    obs_t exp;
  } step_t;

  step_t sb[$];
  int    checks = 0;
  int    errors = 0;

  function automatic obs_t sample();
    return {bus.busy, bus.done, bus.err, bus.gp, bus.layer, bus.level,
            bus.neu_start, bus.neu_rst, bus.ld, bus.ld_ans};
  endfunction

  function automatic obs_t base(input int g, input int lyr, input int lv);
    obs_t e;
    e       = '0;
    e.busy  = 1'b1;
    e.gp    = 2'(g);
    e.layer = 1'(lyr);
    e.level = 3'(lv);
    return e;
  endfunction

  task automatic check(input string tag, input obs_t got, input obs_t exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic fin, input obs_t e);
    step_t s;
    s.fin = fin;
    s.exp = e;
    sb.push_back(s);
  endtask

  // One neuron group: CLR, RUN levels, WAIT, STORE (or a full timeout ending in an err cycle).
  task automatic push_group(input int lyr, input int g, input int early_lv, input bit tmo);
    int   lv_n;
    obs_t e;
    lv_n = (lyr != 0) ? 4 : 8;
    e = base(g, lyr, 0);
    e.nrst = 1'b1;
    push(1'b0, e);
    for (int lv = 0; lv < lv_n; lv++) begin
      e = base(g, lyr, lv);
      e.start = (lv == 0);
      push(lv == early_lv, e);
    end
    if (tmo) begin
      for (int i = 0; i < 64; i++) push(1'b0, base(g, lyr, lv_n - 1));
      e = '0;
      e.err = 1'b1;
      push(1'b0, e);
      return;
    end
    push(early_lv < 0, base(g, lyr, lv_n - 1));
    e = base(g, lyr, lv_n - 1);
    if (lyr == 0) e.ld  = 4'b0001 << g;
    else          e.ans = 2'b01 << g;
    push(1'b0, e);
  endtask

  task automatic push_run(input bit early, input bit tmo);
    obs_t e;
    for (int g = 0; g < 4; g++) push_group(0, g, (early && g == 1) ? 3 : -1, 1'b0);
    push_group(1, 0, -1, tmo);
    if (tmo) return;
    push_group(1, 1, -1, 1'b0);
    e = base(1, 1, 3);
    e.done = 1'b1;
    push(1'b0, e);
  endtask

  task automatic push_idle();
    push(1'b0, obs_t'(0));
  endtask

  // Pops one expectation per clock, sampled 1 time unit after the rising edge.
  task automatic run_sched(input string name, input bit hold_go);
    step_t s;
    int    c;
    c = 0;
    while (sb.size() > 0) begin
      @(posedge clk);
      #1;
      s = sb.pop_front();
      if (c == 0 && !hold_go) bus.go = 1'b0;
      check($sformatf("%s cyc%0d", name, c), sample(), s.exp);
      bus.neu_finish = s.fin;
      c++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst            = 1'b1;
    bus.go         = 1'b0;
    bus.neu_finish = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("in_reset", sample(), obs_t'(0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", sample(), obs_t'(0));

    // Nominal inference: done at cycle 58, idle at 59.
    bus.go = 1'b1;
    push_run(1'b0, 1'b0);
    push_idle();
    run_sched("nominal", 1'b0);

    // Early finish during layer-0 group 1 RUN; WAIT still lasts one cycle.
    bus.go = 1'b1;
    push_run(1'b1, 1'b0);
    push_idle();
    run_sched("early", 1'b0);

    // Withhold finish in layer-1 group 0: 64 WAIT cycles, err pulse, back to idle.
    bus.go = 1'b1;
    push_run(1'b0, 1'b1);
    push_idle();
    run_sched("timeout", 1'b0);

    bus.go = 1'b1;
    push_run(1'b0, 1'b0);
    push_idle();
    run_sched("after_timeout", 1'b0);

    // Async reset in the layer-0 group 3 STORE cycle.
    bus.go = 1'b1;
    for (int g = 0; g < 4; g++) push_group(0, g, -1, 1'b0);
    run_sched("pre_reset", 1'b0);
    bus.neu_finish = 1'b0;
    #3 rst = 1'b1;
    #1;
    check("async_reset_kill", sample(), obs_t'(0));
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_async_reset", sample(), obs_t'(0));

    bus.go = 1'b1;
    push_run(1'b0, 1'b0);
    push_idle();
    run_sched("after_reset", 1'b0);

    // go held high: no restart mid-run, second run begins straight after the idle cycle.
    bus.go = 1'b1;
    push_run(1'b0, 1'b0);
    push_idle();
    push_run(1'b0, 1'b0);
    push_idle();
    run_sched("go_held", 1'b1);
    bus.go = 1'b0;
    @(posedge clk);
    #1;
    check("final_idle", sample(), obs_t'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ann_sequencer.md
Name: ann_sequencer

Overview:
- FSM controller that drives the two-layer neural-network datapath through a full inference.
- Steps through hidden layer (layer 0) neuron groups, then output layer (layer 1) groups.
- Generates gp/layer/level addressing, Neurons start/clear, and one-hot load strobes for the hidden registers (ld) and answer registers (ld_ans).
- Sits between the top-level go/done handshake and the datapath.

Parameters:
- L0_GROUPS, 4, neuron groups in layer 0 (gp 0..3)
- L0_LEVELS, 8, input chunks per layer-0 group (level 0..7)
- L1_GROUPS, 2, neuron groups in layer 1 (gp 0..1)
- L1_LEVELS, 4, input chunks per layer-1 group (level 0..3)
- TIMEOUT, 64, max WAIT cycles for neu_finish before abort

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start inference; sampled only in IDLE
- neu_finish  in  1  Neurons accumulation complete
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: inference complete, answers valid
- err  out  1  one-cycle pulse: WAIT timeout abort
- gp  out  2  current neuron group
- layer  out  1  0 = hidden layer, 1 = output layer
- level  out  3  current input chunk / weight row
- neu_start  out  1  one-cycle pulse; first RUN cycle of each group
- neu_rst  out  1  Neurons accumulator clear; high during CLR only
- ld  out  4  one-hot hidden-register load (ld[gp])
- ld_ans  out  2  one-hot answer-register load (ld_ans[gp[0]])

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset: state IDLE, every output 0, counters 0, finish latch 0.
- All outputs are registered, decoded from the next state.
- States: IDLE, CLR, RUN, WAIT, STORE, DONE.
- IDLE -> CLR when go=1. go while busy is ignored (no queuing).
- CLR (1 cycle): neu_rst=1, level=0, finish latch cleared -> RUN.
- RUN (LEVELS cycles, L0_LEVELS or L1_LEVELS per layer):
  - neu_start=1 in the first RUN cycle only.
  - level increments 0..LEVELS-1, one per cycle.
  - After the last level -> WAIT.
- Memories read synchronously, so data trails level by one cycle; the Neurons block absorbs this.
- neu_finish asserted during RUN is latched; WAIT then exits on its first cycle.
- WAIT: level holds LEVELS-1.
  - Exit to STORE on (neu_finish | latch).
  - Timeout counter increments each WAIT cycle; reaching TIMEOUT -> IDLE with err=1 for one cycle. No load strobe is issued.
- STORE (1 cycle):
  - layer 0: ld[gp]=1.
  - layer 1: ld_ans[gp[0]]=1.
  - Never more than one ld/ld_ans bit high at once.
- After STORE, routing:
  - gp < GROUPS-1: gp+1 -> CLR.
  - Last layer-0 group: layer=1, gp=0 -> CLR.
  - Last layer-1 group -> DONE.
- DONE (1 cycle): done=1, busy=1 -> IDLE. gp, layer and level return to 0 on entering IDLE.
- gp width rule: layer 1 drives only values 0..L1_GROUPS-1; gp[1]=0.
- rst mid-operation: immediate return to IDLE.
  - Any pending ld/ld_ans/neu_start pulse is killed in the same cycle (asynchronous).
  - No done and no err.
- Nominal latency, with neu_finish in the first WAIT cycle:
  - Layer-0 group: 11 cycles (1+8+1+1).
  - Layer-1 group: 7 cycles.
  - First CLR = cycle 0; DONE in cycle 58.

Test Plan:
- Nominal run: pulse go; model returns neu_finish 1 cycle after each RUN ends -> exactly four ld pulses (0001, 0010, 0100, 1000), then ld_ans 01, 10; done in cycle 58; busy low in cycle 59.
- Level/start check: during layer-0 group 2 -> gp=2, layer=0, level steps 0..7 across 8 cycles; neu_start high only alongside level=0; neu_rst high exactly the cycle before.
- Early finish: assert neu_finish during RUN of group 1 -> latched; WAIT lasts 1 cycle; ld=0010 follows; total cycle count unchanged.
- Timeout: withhold neu_finish in layer-1 group 0 -> err pulse after 64 WAIT cycles; no ld_ans strobe, no done; state IDLE; a fresh go restarts at gp=0, layer=0.
- Async reset mid-STORE: assert rst between edges during the layer-0 group 3 STORE -> ld drops to 0 immediately; all outputs 0; later go produces a full nominal run.
- go while busy: hold go=1 throughout a run -> no restart mid-run; after DONE, IDLE accepts go and a second run starts the next cycle.
